// File: rtl/mult_div_unit_pkg.sv
// Shared encodings and helpers for the iterative multiply/divide unit.
// Op and state encodings plus the fixed iteration count.
package mult_div_unit_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'b00,
        MDU_CALC = 2'b01,
        MDU_FIX  = 2'b10
    } mdu_state_e;

    localparam int MDU_ITERS = 32;

    function automatic logic [31:0] mag32(input logic [31:0] v,
                                          input logic       is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO.
// 33 cycles per operation: 32 CALC iterations plus one FIX write.
module mult_div_unit
    import mult_div_unit_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] write_data,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    localparam logic [4:0] LAST = 5'(MDU_ITERS - 1);

    mdu_state_e  state_q, state_d;
    logic        is_div_q, is_div_d;
    logic        neg_q, neg_d;
    logic        rneg_q, rneg_d;
    logic        bz_q, bz_d;
    logic [31:0] orig_a_q, orig_a_d;
    logic [31:0] opnd_q, opnd_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] wlo_q, wlo_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;
    logic        dz_q, dz_d;

    mdu_op_e     op_e;
    logic        op_signed;
    logic        op_div;
    logic [31:0] mag_a, mag_b;
    logic [32:0] sum;
    logic [32:0] rem_sh;
    logic        ge;
    logic [63:0] prod, prod_fix;
    logic [31:0] quo_fix, rem_fix;
    logic [31:0] res_hi, res_lo;

    assign op_e      = mdu_op_e'(op);
    assign op_signed = (op_e == MDU_MULT) || (op_e == MDU_DIV);
    assign op_div    = (op_e == MDU_DIV) || (op_e == MDU_DIVU);
    assign mag_a     = mag32(operand_a, op_signed);
    assign mag_b     = mag32(operand_b, op_signed);

    // Sign correction and divide-by-zero override feed the FIX write
    assign prod     = {acc_q, wlo_q};
    assign prod_fix = neg_q ? (~prod + 64'd1) : prod;
    assign quo_fix  = neg_q ? (~wlo_q + 32'd1) : wlo_q;
    assign rem_fix  = rneg_q ? (~acc_q + 32'd1) : acc_q;

    always_comb begin
        res_hi = prod_fix[63:32];
        res_lo = prod_fix[31:0];
        if (is_div_q) begin
            if (bz_q) begin
                res_hi = orig_a_q;
                res_lo = 32'hFFFF_FFFF;
            end else begin
                res_hi = rem_fix;
                res_lo = quo_fix;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        bz_d     = bz_q;
        orig_a_d = orig_a_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        wlo_d    = wlo_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dz_d     = dz_q;
        sum      = '0;
        rem_sh   = '0;
        ge       = 1'b0;
        unique case (state_q)
            MDU_IDLE: begin
                if (start) begin
                    state_d  = MDU_CALC;
                    is_div_d = op_div;
                    neg_d    = op_signed & (operand_a[31] ^ operand_b[31]);
                    rneg_d   = op_signed & operand_a[31];
                    bz_d     = (operand_b == 32'd0);
                    orig_a_d = operand_a;
                    opnd_d   = op_div ? mag_b : mag_a;
                    wlo_d    = op_div ? mag_a : mag_b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    dz_d     = 1'b0;
                end else begin
                    if (mthi) hi_d = write_data;
                    if (mtlo) lo_d = write_data;
                end
            end
            MDU_CALC: begin
                if (is_div_q) begin
                    rem_sh = {acc_q, wlo_q[31]};
                    ge     = (rem_sh >= {1'b0, opnd_q});
                    acc_d  = ge ? 32'(rem_sh - {1'b0, opnd_q})
                                : rem_sh[31:0];
                    wlo_d  = {wlo_q[30:0], ge};
                end else begin
                    sum   = {1'b0, acc_q}
                          + (wlo_q[0] ? {1'b0, opnd_q} : 33'd0);
                    acc_d = sum[32:1];
                    wlo_d = {sum[0], wlo_q[31:1]};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LAST) state_d = MDU_FIX;
            end
            MDU_FIX: begin
                hi_d    = res_hi;
                lo_d    = res_lo;
                done_d  = 1'b1;
                dz_d    = is_div_q & bz_q;
                state_d = MDU_IDLE;
            end
            default: state_d = MDU_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= MDU_IDLE;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            bz_q     <= 1'b0;
            orig_a_q <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            wlo_q    <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            bz_q     <= bz_d;
            orig_a_q <= orig_a_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            wlo_q    <= wlo_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
        end
    end

    assign busy        = (state_q != MDU_IDLE);
    assign done        = done_q;
    assign div_by_zero = dz_q;
    assign hi_out      = hi_q;
    assign lo_out      = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: driver queues expected HI/LO,
// a monitor pops and compares on every done pulse.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        mthi;
    logic        mtlo;
    logic [31:0] write_data;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;

    mult_div_unit dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .mthi        (mthi),
        .mtlo        (mtlo),
        .write_data  (write_data),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi_out      (hi_out),
        .lo_out      (lo_out)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %08h, expected %08h", name, act, req);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on the architectural rules
    function automatic exp_t model(input logic [1:0] o,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        exp_t r;
        longint sa, sb, p;
        longint unsigned up;
        r.dz = 1'b0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'b00: begin
                p = sa * sb;
                r.hi = p[63:32];
                r.lo = p[31:0];
            end
            2'b01: begin
                up = {32'b0, a} * {32'b0, b};
                r.hi = up[63:32];
                r.lo = up[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    r.hi = a;
                    r.lo = 32'hFFFF_FFFF;
                    r.dz = 1'b1;
                end else if (o == 2'b10) begin
                    p = sa / sb;
                    r.lo = p[31:0];
                    p = sa % sb;
                    r.hi = p[31:0];
                end else begin
                    r.lo = a / b;
                    r.hi = a % b;
                end
            end
        endcase
        return r;
    endfunction

    always @(negedge clock) begin
        if (reset === 1'b0 && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1, expected none");
            end else begin
                mon_e = exp_q.pop_front();
                check("hi", hi_out, mon_e.hi);
                check("lo", lo_out, mon_e.lo);
                check("div_by_zero", {31'b0, div_by_zero}, {31'b0, mon_e.dz});
            end
        end
    end

    task automatic do_op(input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input bit interfere,
                         input bit with_mtlo);
        logic [31:0] h0, l0;
        int n;
        bit ok;
        @(negedge clock);
        op         = o;
        operand_a  = a;
        operand_b  = b;
        start      = 1'b1;
        mtlo       = with_mtlo;
        write_data = 32'hDEAD_BEEF;
        exp_q.push_back(model(o, a, b));
        @(posedge clock);
        #1;
        start = 1'b0;
        mtlo  = 1'b0;
        h0 = hi_out;
        l0 = lo_out;
        check("busy_after_accept", {31'b0, busy}, 32'd1);
        check("dz_cleared_on_accept", {31'b0, div_by_zero}, 32'd0);
        n  = 0;
        ok = 1'b1;
        while (done !== 1'b1 && n < 40) begin
            if (interfere && n == 5) begin
                start      = 1'b1;
                op         = MDU_MULTU;
                operand_a  = 32'd3;
                operand_b  = 32'd3;
                mthi       = 1'b1;
                write_data = 32'hAAAA_5555;
            end else if (n == 6) begin
                start = 1'b0;
                mthi  = 1'b0;
            end
            @(posedge clock);
            #1;
            n++;
            if (done !== 1'b1 &&
                (busy !== 1'b1 || hi_out !== h0 || lo_out !== l0))
                ok = 1'b0;
        end
        check("latency", n, 32'd33);
        check("busy_low_at_done", {31'b0, busy}, 32'd0);
        check("hilo_stable_while_busy", {31'b0, ok}, 32'd1);
    endtask

    task automatic move(input bit h, input bit l, input logic [31:0] d);
        logic [31:0] h0, l0;
        h0 = hi_out;
        l0 = lo_out;
        @(negedge clock);
        mthi       = h;
        mtlo       = l;
        write_data = d;
        @(posedge clock);
        #1;
        mthi = 1'b0;
        mtlo = 1'b0;
        check("move_hi", hi_out, h ? d : h0);
        check("move_lo", lo_out, l ? d : l0);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        int          mode;
        reset      = 1'b1;
        start      = 1'b0;
        op         = 2'b00;
        operand_a  = '0;
        operand_b  = '0;
        mthi       = 1'b0;
        mtlo       = 1'b0;
        write_data = '0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_hi", hi_out, 32'd0);
        check("reset_lo", lo_out, 32'd0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_dz", {31'b0, div_by_zero}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        do_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        do_op(MDU_MULT,  32'hFFFF_FFFD, 32'd5,         1'b0, 1'b0);
        do_op(MDU_MULT,  32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        do_op(MDU_DIV,   32'hFFFF_FFF9, 32'd2,         1'b0, 1'b0);
        do_op(MDU_DIVU,  32'd7,         32'd2,         1'b0, 1'b0);
        do_op(MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        do_op(MDU_DIVU,  32'h1234_5678, 32'd0,         1'b0, 1'b0);
        do_op(MDU_DIV,   32'd100,       32'hFFFF_FFF9, 1'b1, 1'b0);
        do_op(MDU_DIVU,  32'd100,       32'd7,         1'b0, 1'b1);

        move(1'b1, 1'b0, 32'hAAAA_5555);
        move(1'b0, 1'b1, 32'h1357_2468);
        move(1'b1, 1'b1, 32'h0F0F_0F0F);

        @(negedge clock);
        op        = MDU_MULTU;
        operand_a = 32'd1000;
        operand_b = 32'd1000;
        start     = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_hi", hi_out, 32'd0);
        check("abort_lo", lo_out, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        exp_q.delete();
        do_op(MDU_MULTU, 32'd6, 32'd7, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            ro   = 2'($urandom_range(0, 3));
            ra   = $urandom();
            rb   = $urandom();
            mode = $urandom_range(0, 7);
            if (mode == 0) rb = 32'd0;
            else if (mode == 1) ra = 32'h8000_0000;
            else if (mode == 2) rb = 32'($urandom_range(1, 15));
            else if (mode == 3) rb = 32'hFFFF_FFFF;
            do_op(ro, ra, rb, 1'b0, 1'b0);
        end

        repeat (3) @(posedge clock);
        #1;
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
